// File: rtl/vend_ledger.sv
// Vending transaction and inventory engine: per-item stock/sold counters,
// purchase and restock sequencing, coin acceptance, change and revenue.
module vend_ledger #(
  parameter int unsigned          N_ITEMS = 4,
  parameter int unsigned          CNT_W   = 4,
  parameter int unsigned          MONEY_W = 8,
  parameter int unsigned          SALE_W  = 12,
  parameter logic [N_ITEMS*8-1:0] PRICES  = {8'd6, 8'd5, 8'd4, 8'd3},
  parameter int unsigned          TIMEOUT = 1000,
  localparam int unsigned         ID_W    = $clog2(N_ITEMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_next,
  input  logic               btn_prev,
  input  logic               btn_plus,
  input  logic               btn_minus,
  input  logic               btn_ok,
  input  logic               btn_cancel,
  input  logic               restock_en,
  input  logic               coin1,
  input  logic               coin2,
  input  logic               coin5,
  input  logic               coin10,
  output logic [ID_W-1:0]    id,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   stock,
  output logic [CNT_W-1:0]   sold,
  output logic [CNT_W-1:0]   qty,
  output logic [MONEY_W-1:0] due,
  output logic [MONEY_W-1:0] paid,
  output logic [MONEY_W-1:0] change,
  output logic [SALE_W-1:0]  sale_total,
  output logic               dispense,
  output logic               coin_reject,
  output logic               err
);

  typedef enum logic [2:0] {
    BROWSE    = 3'd0,
    QTY       = 3'd1,
    PAY       = 3'd2,
    VEND      = 3'd3,
    REFUND    = 3'd4,
    RESTOCK   = 3'd5,
    RS_COMMIT = 3'd6
  } state_e;

  localparam int unsigned      TO_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N_ITEMS - 1);
  localparam logic [CNT_W-1:0] MAX_STOCK = '1;
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [CNT_W-1:0]     qty_q, qty_d;
  logic [MONEY_W-1:0]   due_q, due_d, paid_q, paid_d, change_q, change_d;
  logic [SALE_W-1:0]    sale_q, sale_d;
  logic [TO_W-1:0]      tmo_q, tmo_d;
  logic                 disp_q, disp_d, rej_q, rej_d, err_q, err_d;
  logic [CNT_W-1:0]     stock_q [N_ITEMS];
  logic [CNT_W-1:0]     sold_q  [N_ITEMS];

  logic                 stock_we, sold_we;
  logic [CNT_W-1:0]     stock_wd, sold_wd;
  logic [CNT_W-1:0]     cur_stock, cur_sold;
  logic [ID_W+2:0]      price_lsb;
  logic [7:0]           price;
  logic [8+CNT_W-1:0]   prod;
  logic [ID_W-1:0]      id_inc, id_dec;
  logic                 nav_next, nav_prev, inc, dec;
  logic [3:0]           coins;
  logic                 coin_any, coin_multi;
  logic [MONEY_W:0]     coin_val, pay_sum;
  logic [CNT_W:0]       rs_sum, sold_sum;

  assign cur_stock  = stock_q[id_q];
  assign cur_sold   = sold_q[id_q];
  assign price_lsb  = {id_q, 3'b000};
  assign price      = PRICES[price_lsb +: 8];
  assign prod       = {{CNT_W{1'b0}}, price} * {8'b0, qty_q};
  assign id_inc     = (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);
  assign id_dec     = (id_q == '0) ? ID_LAST : id_q - ID_W'(1);
  assign nav_next   = btn_next & ~btn_prev;
  assign nav_prev   = btn_prev & ~btn_next;
  assign inc        = btn_plus & ~btn_minus;
  assign dec        = btn_minus & ~btn_plus;
  assign coins      = {coin10, coin5, coin2, coin1};
  assign coin_any   = |coins;
  assign coin_multi = (coins & (coins - 4'd1)) != 4'd0;
  assign pay_sum    = {1'b0, paid_q} + coin_val;
  assign rs_sum     = {1'b0, cur_stock} + {1'b0, qty_q};
  assign sold_sum   = {1'b0, cur_sold} + {1'b0, qty_q};

  always_comb begin
    coin_val = '0;
    if (coin10)     coin_val = (MONEY_W+1)'(10);
    else if (coin5) coin_val = (MONEY_W+1)'(5);
    else if (coin2) coin_val = (MONEY_W+1)'(2);
    else if (coin1) coin_val = (MONEY_W+1)'(1);
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    qty_d    = qty_q;
    due_d    = due_q;
    paid_d   = paid_q;
    change_d = change_q;
    sale_d   = sale_q;
    tmo_d    = tmo_q;
    disp_d   = 1'b0;
    rej_d    = 1'b0;
    err_d    = 1'b0;
    stock_we = 1'b0;
    stock_wd = cur_stock;
    sold_we  = 1'b0;
    sold_wd  = sold_sum[CNT_W] ? MAX_STOCK : sold_sum[CNT_W-1:0];
    case (state_q)
      BROWSE: begin
        if (restock_en) begin
          state_d = RESTOCK;
          qty_d   = '0;
        end else if (btn_ok) begin
          if (cur_stock != '0) begin
            state_d  = QTY;
            qty_d    = CNT_W'(1);
            change_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end else if (nav_next) begin
          id_d = id_inc;
        end else if (nav_prev) begin
          id_d = id_dec;
        end
      end
      QTY: begin
        if (btn_cancel) begin
          state_d = BROWSE;
          qty_d   = '0;
        end else if (btn_ok) begin
          state_d = PAY;
          paid_d  = '0;
          due_d   = MONEY_W'(prod);
          tmo_d   = '0;
        end else if (inc) begin
          if (qty_q < cur_stock) qty_d = qty_q + CNT_W'(1);
          else                   err_d = 1'b1;
        end else if (dec) begin
          if (qty_q > CNT_W'(1)) qty_d = qty_q - CNT_W'(1);
          else                   err_d = 1'b1;
        end
      end
      PAY: begin
        // Any coin, accepted or refused, restarts the idle window.
        if (btn_cancel) begin
          state_d = REFUND;
        end else if (coin_any) begin
          tmo_d = '0;
          if (coin_multi || pay_sum[MONEY_W]) begin
            rej_d = 1'b1;
          end else begin
            paid_d = pay_sum[MONEY_W-1:0];
            if (pay_sum[MONEY_W-1:0] >= due_q) state_d = VEND;
          end
        end else if (tmo_q == TO_LAST) begin
          state_d = REFUND;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      VEND: begin
        stock_we = 1'b1;
        stock_wd = cur_stock - qty_q;
        sold_we  = 1'b1;
        sale_d   = sale_q + SALE_W'(due_q);
        change_d = paid_q - due_q;
        disp_d   = 1'b1;
        state_d  = BROWSE;
      end
      REFUND: begin
        change_d = paid_q;
        paid_d   = '0;
        state_d  = BROWSE;
      end
      RESTOCK: begin
        if (!restock_en) begin
          state_d = BROWSE;
          qty_d   = '0;
        end else if (btn_ok) begin
          state_d = RS_COMMIT;
        end else if (nav_next) begin
          id_d  = id_inc;
          qty_d = '0;
        end else if (nav_prev) begin
          id_d  = id_dec;
          qty_d = '0;
        end else if (inc) begin
          if (rs_sum < {1'b0, MAX_STOCK}) qty_d = qty_q + CNT_W'(1);
          else                            err_d = 1'b1;
        end else if (dec) begin
          if (qty_q != '0) qty_d = qty_q - CNT_W'(1);
          else             err_d = 1'b1;
        end
      end
      RS_COMMIT: begin
        stock_we = 1'b1;
        stock_wd = rs_sum[CNT_W-1:0];
        qty_d    = '0;
        state_d  = RESTOCK;
      end
      default: state_d = BROWSE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BROWSE;
      id_q     <= '0;
      qty_q    <= '0;
      due_q    <= '0;
      paid_q   <= '0;
      change_q <= '0;
      sale_q   <= '0;
      tmo_q    <= '0;
      disp_q   <= 1'b0;
      rej_q    <= 1'b0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= '0;
        sold_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      qty_q    <= qty_d;
      due_q    <= due_d;
      paid_q   <= paid_d;
      change_q <= change_d;
      sale_q   <= sale_d;
      tmo_q    <= tmo_d;
      disp_q   <= disp_d;
      rej_q    <= rej_d;
      err_q    <= err_d;
      if (stock_we) stock_q[id_q] <= stock_wd;
      if (sold_we)  sold_q[id_q]  <= sold_wd;
    end
  end

  assign id          = id_q;
  assign state       = state_q;
  assign stock       = cur_stock;
  assign sold        = cur_sold;
  assign qty         = qty_q;
  assign due         = due_q;
  assign paid        = paid_q;
  assign change      = change_q;
  assign sale_total  = sale_q;
  assign dispense    = disp_q;
  assign coin_reject = rej_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vend_ledger.sv
// Directed scoreboard bench for vend_ledger: expectations are queued as
// stimulus is applied and checked one time step after the following edge.
module tb_vend_ledger;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_next, btn_prev, btn_plus, btn_minus, btn_ok, btn_cancel;
  logic restock_en, coin1, coin2, coin5, coin10;
  logic [1:0]  id;
  logic [2:0]  state;
  logic [3:0]  stock, sold, qty;
  logic [7:0]  due, paid, change;
  logic [11:0] sale_total;
  logic        dispense, coin_reject, err;

  vend_ledger #(
    .N_ITEMS (4),
    .CNT_W   (4),
    .MONEY_W (8),
    .SALE_W  (12),
    .PRICES  ({8'd6, 8'd5, 8'd255, 8'd3}),
    .TIMEOUT (TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_plus(btn_plus),
    .btn_minus(btn_minus), .btn_ok(btn_ok), .btn_cancel(btn_cancel),
    .restock_en(restock_en),
    .coin1(coin1), .coin2(coin2), .coin5(coin5), .coin10(coin10),
    .id(id), .state(state), .stock(stock), .sold(sold), .qty(qty),
    .due(due), .paid(paid), .change(change), .sale_total(sale_total),
    .dispense(dispense), .coin_reject(coin_reject), .err(err)
  );

  always #5 clk = ~clk;

  typedef enum int {S_STATE, S_ID, S_STOCK, S_SOLD, S_QTY, S_DUE, S_PAID,
                    S_CHANGE, S_SALE, S_DISP, S_REJ, S_ERR} sig_e;
  typedef struct {
    sig_e        sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic logic [31:0] observe(input sig_e s);
    logic [31:0] v;
    v = '0;
    case (s)
      S_STATE:  v = 32'(state);
      S_ID:     v = 32'(id);
      S_STOCK:  v = 32'(stock);
      S_SOLD:   v = 32'(sold);
      S_QTY:    v = 32'(qty);
      S_DUE:    v = 32'(due);
      S_PAID:   v = 32'(paid);
      S_CHANGE: v = 32'(change);
      S_SALE:   v = 32'(sale_total);
      S_DISP:   v = 32'(dispense);
      S_REJ:    v = 32'(coin_reject);
      S_ERR:    v = 32'(err);
      default:  v = 'x;
    endcase
    return v;
  endfunction

  task automatic ex(input sig_e s, input int unsigned v, input string tag);
    exp_t e;
    e.sel = s;
    e.exp = 32'(v);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic ex_reset(input string p);
    ex(S_STATE, 0, {p, "_state"});  ex(S_ID, 0, {p, "_id"});
    ex(S_STOCK, 0, {p, "_stock"});  ex(S_SOLD, 0, {p, "_sold"});
    ex(S_QTY, 0, {p, "_qty"});      ex(S_DUE, 0, {p, "_due"});
    ex(S_PAID, 0, {p, "_paid"});    ex(S_CHANGE, 0, {p, "_change"});
    ex(S_SALE, 0, {p, "_sale"});    ex(S_DISP, 0, {p, "_disp"});
    ex(S_REJ, 0, {p, "_rej"});      ex(S_ERR, 0, {p, "_err"});
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    {btn_next, btn_prev, btn_plus, btn_minus, btn_ok, btn_cancel} = '0;
    {coin1, coin2, coin5, coin10} = '0;
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {btn_next, btn_prev, btn_plus, btn_minus, btn_ok, btn_cancel} = '0;
    {restock_en, coin1, coin2, coin5, coin10} = '0;
    #12;
    ex_reset("rst");
    drain();
    @(negedge clk) rst_n = 1'b1;

    // Navigation wrap and simultaneous next/prev.
    btn_prev = 1; ex(S_ID, 3, "wrap_prev"); cycle();
    btn_next = 1; ex(S_ID, 0, "wrap_next"); cycle();
    btn_next = 1; btn_prev = 1; ex(S_ID, 0, "nav_both"); cycle();

    // ok on an empty item.
    btn_ok = 1; ex(S_ERR, 1, "empty_err"); ex(S_STATE, 0, "empty_stay"); ex(S_QTY, 0, "empty_qty"); cycle();
    ex(S_ERR, 0, "err_pulse"); cycle();

    // Restock items 1, 2 and 3.
    restock_en = 1; ex(S_STATE, 5, "rs_enter"); ex(S_QTY, 0, "rs_qty0"); cycle();
    btn_next = 1; ex(S_ID, 1, "rs_id1"); cycle();
    btn_plus = 1; ex(S_QTY, 1, "rs_qty_i1"); cycle();
    btn_ok = 1; ex(S_STATE, 6, "rs_commit1"); cycle();
    ex(S_STATE, 5, "rs_back1"); ex(S_STOCK, 1, "rs_stock1"); ex(S_QTY, 0, "rs_qty_clr1"); cycle();
    btn_next = 1; ex(S_ID, 2, "rs_id2"); ex(S_STOCK, 0, "rs_stock2_pre"); cycle();
    for (int i = 1; i <= 5; i++) begin
      btn_plus = 1; ex(S_QTY, i, "rs_qty_i2"); cycle();
    end
    btn_ok = 1; ex(S_STATE, 6, "rs_commit2"); cycle();
    ex(S_STATE, 5, "rs_back2"); ex(S_STOCK, 5, "rs_stock2"); cycle();
    btn_next = 1; ex(S_ID, 3, "rs_id3"); cycle();
    for (int i = 1; i <= 15; i++) begin
      btn_plus = 1; ex(S_QTY, i, "rs_qty_i3"); cycle();
    end
    btn_plus = 1; ex(S_ERR, 1, "rs_limit_err"); ex(S_QTY, 15, "rs_limit_qty"); cycle();
    btn_ok = 1; ex(S_STATE, 6, "rs_commit3"); cycle();
    ex(S_STOCK, 15, "rs_stock3"); cycle();
    restock_en = 0; ex(S_STATE, 0, "rs_exit"); ex(S_ID, 3, "rs_exit_id"); cycle();

    // Purchase 2 of item 2, exact payment.
    btn_prev = 1; ex(S_ID, 2, "buy_id"); ex(S_STOCK, 5, "buy_stock"); cycle();
    btn_ok = 1; ex(S_STATE, 1, "buy_qty_state"); ex(S_QTY, 1, "buy_qty1"); cycle();
    btn_plus = 1; ex(S_QTY, 2, "buy_qty2"); cycle();
    btn_ok = 1; ex(S_STATE, 2, "buy_pay"); ex(S_DUE, 10, "buy_due"); ex(S_PAID, 0, "buy_paid0"); cycle();
    coin10 = 1; ex(S_STATE, 3, "buy_vend"); ex(S_PAID, 10, "buy_paid"); ex(S_DISP, 0, "buy_disp_early"); cycle();
    ex(S_STATE, 0, "buy_done"); ex(S_DISP, 1, "buy_disp"); ex(S_CHANGE, 0, "buy_change");
    ex(S_STOCK, 3, "buy_stock_after"); ex(S_SOLD, 2, "buy_sold"); ex(S_SALE, 10, "buy_sale"); cycle();
    ex(S_DISP, 0, "disp_pulse"); cycle();

    // Quantity limits, plus+minus together, cancel over ok.
    btn_ok = 1; ex(S_QTY, 1, "lim_qty1"); cycle();
    btn_plus = 1; ex(S_QTY, 2, "lim_qty2"); cycle();
    btn_plus = 1; ex(S_QTY, 3, "lim_qty3"); cycle();
    btn_plus = 1; ex(S_ERR, 1, "qty_max_err"); ex(S_QTY, 3, "qty_max"); cycle();
    btn_plus = 1; btn_minus = 1; ex(S_QTY, 3, "pm_both"); ex(S_ERR, 0, "pm_both_err"); cycle();
    btn_minus = 1; ex(S_QTY, 2, "lim_dec2"); cycle();
    btn_minus = 1; ex(S_QTY, 1, "lim_dec1"); cycle();
    btn_minus = 1; ex(S_ERR, 1, "qty_min_err"); ex(S_QTY, 1, "qty_min"); cycle();
    btn_cancel = 1; btn_ok = 1; ex(S_STATE, 0, "cancel_prio"); cycle();

    // Item 3 with change.
    btn_next = 1; ex(S_ID, 3, "chg_id"); ex(S_STOCK, 15, "chg_stock"); cycle();
    btn_ok = 1; ex(S_STATE, 1, "chg_qty"); cycle();
    btn_ok = 1; ex(S_DUE, 6, "chg_due"); cycle();
    coin5 = 1; ex(S_PAID, 5, "chg_paid5"); ex(S_STATE, 2, "chg_pay"); cycle();
    coin2 = 1; ex(S_PAID, 7, "chg_paid7"); ex(S_STATE, 3, "chg_vend"); cycle();
    ex(S_CHANGE, 1, "chg_change"); ex(S_SALE, 16, "chg_sale"); ex(S_STOCK, 14, "chg_stock_after");
    ex(S_SOLD, 1, "chg_sold"); ex(S_DISP, 1, "chg_disp"); cycle();

    // Coin rejection on item 1 (price 255).
    btn_prev = 1; ex(S_ID, 2, "rej_nav2"); cycle();
    btn_prev = 1; ex(S_ID, 1, "rej_id"); ex(S_STOCK, 1, "rej_stock"); cycle();
    btn_ok = 1; ex(S_CHANGE, 0, "change_clear"); cycle();
    btn_ok = 1; ex(S_DUE, 255, "rej_due"); cycle();
    coin1 = 1; coin5 = 1; ex(S_REJ, 1, "multi_rej"); ex(S_PAID, 0, "multi_paid"); cycle();
    ex(S_REJ, 0, "rej_pulse"); cycle();
    for (int i = 1; i <= 25; i++) begin
      coin10 = 1; ex(S_PAID, 10 * i, "fill_paid"); ex(S_STATE, 2, "fill_state"); cycle();
    end
    coin10 = 1; ex(S_REJ, 1, "ovf_rej"); ex(S_PAID, 250, "ovf_paid"); ex(S_STATE, 2, "ovf_state"); cycle();
    coin5 = 1; ex(S_PAID, 255, "rej_paid_full"); ex(S_STATE, 3, "rej_vend"); cycle();
    ex(S_DISP, 1, "big_disp"); ex(S_SALE, 271, "big_sale"); ex(S_CHANGE, 0, "big_change");
    ex(S_STOCK, 0, "big_stock"); ex(S_SOLD, 1, "big_sold"); cycle();

    // Cancel refund on item 3.
    btn_next = 1; ex(S_ID, 2, "ref_nav2"); cycle();
    btn_next = 1; ex(S_ID, 3, "ref_id"); cycle();
    btn_ok = 1; ex(S_STATE, 1, "ref_qty"); cycle();
    btn_ok = 1; ex(S_STATE, 2, "ref_pay"); cycle();
    coin5 = 1; ex(S_PAID, 5, "ref_paid"); cycle();
    btn_cancel = 1; ex(S_STATE, 4, "ref_state"); ex(S_PAID, 5, "ref_paid_hold"); cycle();
    ex(S_STATE, 0, "ref_done"); ex(S_CHANGE, 5, "ref_change"); ex(S_PAID, 0, "ref_paid0");
    ex(S_STOCK, 14, "ref_stock"); ex(S_DISP, 0, "ref_nodisp"); cycle();

    // Timeout refund.
    btn_ok = 1; ex(S_CHANGE, 0, "to_change_clr"); cycle();
    btn_ok = 1; ex(S_STATE, 2, "to_pay"); cycle();
    coin5 = 1; ex(S_PAID, 5, "to_paid"); cycle();
    for (int i = 1; i < int'(TO); i++) begin
      ex(S_STATE, 2, "to_wait"); cycle();
    end
    ex(S_STATE, 4, "timeout"); cycle();
    ex(S_STATE, 0, "to_done"); ex(S_CHANGE, 5, "to_change"); ex(S_PAID, 0, "to_paid0");
    ex(S_STOCK, 14, "to_stock"); cycle();

    // Asynchronous reset during PAY.
    btn_ok = 1; cycle();
    btn_ok = 1; ex(S_STATE, 2, "ar_pay"); cycle();
    coin5 = 1; ex(S_PAID, 5, "ar_paid"); cycle();
    #2;
    rst_n = 1'b0;
    #1;
    ex_reset("async");
    drain();
    for (int i = 0; i < 3; i++) begin
      btn_ok = 1; coin10 = 1; btn_next = 1;
      ex_reset("hold");
      cycle();
    end
    @(negedge clk) rst_n = 1'b1;
    ex(S_STATE, 0, "post_state"); ex(S_STOCK, 0, "post_stock"); ex(S_SALE, 0, "post_sale"); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_ledger.md
# vend_ledger

Parametrised transaction and inventory engine for the vending machine. It owns per-item stock and sales counters and runs browse/quantity/pay/restock as an internal FSM driven by one-cycle button and coin pulses. It computes amount due, amount paid, change and cumulative sales revenue. It sits between the debounced input layer and the display/dispense drivers, and supersedes the externally-sequenced calculation block with N items, configurable widths, refund on cancel and payment timeout.

## Interface
- N_ITEMS, 4, number of products (2..16); ID_W = clog2(N_ITEMS)
- CNT_W, 4, stock/sold counter width; MAX_STOCK = 2^CNT_W-1
- MONEY_W, 8, width of paid/due/change
- SALE_W, 12, width of cumulative revenue
- PRICES, {8'd6,8'd5,8'd4,8'd3}, packed N_ITEMS×8 price list, item 0 in LSBs
- TIMEOUT, 1000, idle cycles in PAY before auto-refund
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_next, btn_prev, btn_plus, btn_minus, btn_ok, btn_cancel  in  1 each  one-cycle button pulses
- restock_en  in  1  level; admin restock mode request
- coin1, coin2, coin5, coin10  in  1 each  one-cycle coin pulses
- id  out  ID_W  selected item
- state  out  3  FSM state code
- stock, sold  out  CNT_W each  stock / sold count of item id
- qty  out  CNT_W  pending purchase or restock quantity
- due, paid, change  out  MONEY_W each  price×qty, coins accepted, change/refund
- sale_total  out  SALE_W  revenue since reset
- dispense  out  1  one-cycle pulse: purchase committed
- coin_reject  out  1  one-cycle pulse: coin refused
- err  out  1  one-cycle pulse: illegal request

## Operation
- States: BROWSE=0, QTY=1, PAY=2, VEND=3, REFUND=4, RESTOCK=5, RS_COMMIT=6.
- BROWSE: next/prev move id by ±1 modulo N_ITEMS. ok → QTY with qty=1 if stock>0; if stock=0, err and stay. restock_en → RESTOCK with qty=0.
- QTY: plus increments qty up to stock; minus decrements qty down to 1; pushes beyond a limit pulse err. ok → PAY with paid=0. cancel → BROWSE.
- PAY: due = PRICES[id]×qty, held registered for the whole state. Coin adds 1/2/5/10 to paid. A coin is rejected (coin_reject, paid unchanged) when more than one coin bit is set in the same cycle or the sum would exceed 2^MONEY_W-1. When paid ≥ due → VEND. cancel or TIMEOUT cycles without a coin → REFUND.
- VEND (1 cycle): stock[id]-=qty; sold[id]+=qty saturating at MAX_STOCK; sale_total+=due wrapping mod 2^SALE_W; change=paid-due; dispense=1 → BROWSE.
- REFUND (1 cycle): change=paid, paid=0 → BROWSE.
- RESTOCK: next/prev change id and reset qty to 0. plus/minus adjust qty in 0..MAX_STOCK-stock. ok → RS_COMMIT. Dropping restock_en → BROWSE with no change.
- RS_COMMIT (1 cycle): stock[id]+=qty, qty=0 → RESTOCK.
- Buttons are ignored in states that do not list them. plus and minus in the same cycle are both ignored, as are next and prev together. cancel has priority over ok. restock_en is sampled only in BROWSE.
- change holds its value until the next entry to QTY clears it.

## Timing
- Reset: state=BROWSE; id=0; every stock, sold, qty, due, paid, change, sale_total=0; dispense, coin_reject, err=0. Reset mid-PAY discards paid with no refund pulse.
- All outputs are registered. A pulse at edge k is visible after edge k. State transitions take one edge.
- A coin that completes payment at edge k gives VEND at k+1, with dispense, change and updated counters all visible after k+1.
- stock and sold are combinationally muxed from the register array by the registered id.
- The timeout counter clears on PAY entry and on every accepted or rejected coin.

## Test plan
- Restock item 2 by 5 → stock=5. Buy 2 → due=10. Insert coin10 → VEND next edge, dispense=1, change=0, stock=3, sold=2, sale_total=10.
- Item 3, qty 1, due=6. Insert coin5 then coin2 → paid=7, change=1.
- Same cycle coin1+coin5 → coin_reject=1, paid unchanged. paid=250 plus coin10 → rejected.
- Pay 5 toward due 6 then cancel → REFUND, change=5, BROWSE, stock unchanged. Repeat with no cancel → refund after exactly TIMEOUT idle cycles.
- ok on an empty item → err, stays in BROWSE. plus at qty==stock → err. Restock plus at stock+qty==15 → err.
- Assert rst_n low during PAY → all outputs return to reset values asynchronously, and stay there until rst_n is released.
